// File: rtl/music_pkg.sv
// Shared types and constants for the melody sequencer: FSM encoding,
// rest code and song-ROM entry layout.
package music_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_HOLD,
    S_DONE
  } state_e;

  localparam int unsigned REST_CODE     = 0;
  localparam int unsigned TEMPO_SHIFT_W = 2;
  localparam int unsigned NOTE_LSB      = 0;

  // ROM entry is {dur, note}; the duration field sits directly above the note
  function automatic int unsigned dur_lsb(input int unsigned note_w);
    return note_w;
  endfunction

  function automatic int unsigned entry_w(input int unsigned note_w, input int unsigned dur_w);
    return note_w + dur_w;
  endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// Control/status bundle between game control (master) and the sequencer (slave).
interface music_sequencer_if
  import music_pkg::*;
#(
  parameter int unsigned NOTE_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic                     play;
  logic                     restart;
  logic                     loop_en;
  logic [TEMPO_SHIFT_W-1:0] tempo_sel;
  logic [NOTE_W-1:0]        note;
  logic                     note_valid;
  logic [ADDR_W-1:0]        address;
  logic                     playing;
  logic                     song_done;

  modport master (
    output play, restart, loop_en, tempo_sel,
    input  note, note_valid, address, playing, song_done
  );

  modport slave (
    input  play, restart, loop_en, tempo_sel,
    output note, note_valid, address, playing, song_done
  );
endinterface

// File: rtl/music_seq_rom.sv
// Synchronous song ROM, one-cycle read latency. Built-in 32-entry melody;
// addresses at or beyond SONG_LEN (or the built-in table) read as zero.
module music_seq_rom
  import music_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned NOTE_W   = 8,
  parameter int unsigned DUR_W    = 4,
  parameter int unsigned SONG_LEN = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         addr_i,
  output logic [NOTE_W+DUR_W-1:0]   data_o
);
  localparam int unsigned ENTRY_W = entry_w(NOTE_W, DUR_W);

  logic [ENTRY_W-1:0] data_q;

  // 8-note phrase repeated four times; the last note of each phrase is held for two beats
  function automatic logic [ENTRY_W-1:0] entry_at(input logic [ADDR_W-1:0] a);
    int unsigned idx;
    int unsigned code;
    int unsigned dur;
    idx = 32'(a);
    case (idx % 8)
      0:       code = 27;
      1:       code = 26;
      2:       code = 27;
      3:       code = 28;
      4:       code = 25;
      5:       code = 26;
      6:       code = 22;
      default: code = 24;
    endcase
    dur = ((idx % 8) == 7) ? 2 : 1;
    if (idx >= SONG_LEN || idx >= 32) return '0;
    return {DUR_W'(dur), NOTE_W'(code)};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= entry_at(addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/music_sequencer.sv
// Self-timed melody player: walks the song ROM, holds each note for
// duration x beat-tick cycles, with pause, restart, looping and tempo select.
module music_sequencer
  import music_pkg::*;
#(
  parameter int unsigned NOTE_W   = 8,
  parameter int unsigned DUR_W    = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned SONG_LEN = 32,
  parameter int unsigned TICK_DIV = 6250000
) (
  input  logic             clk,
  input  logic             rst_n,
  music_sequencer_if.slave bus
);
  localparam int unsigned TICK_W  = $clog2(TICK_DIV);
  localparam int unsigned ENTRY_W = entry_w(NOTE_W, DUR_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [NOTE_W-1:0]   note_q,  note_d;
  logic                nv_q,    nv_d;
  logic                done_q,  done_d;
  logic [TICK_W-1:0]   tick_q,  tick_d;
  logic [DUR_W-1:0]    dur_q,   dur_d;

  logic [ENTRY_W-1:0]  rom_data;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic [31:0]         tick_last;
  logic                tick_end;
  logic                last_entry;

  music_seq_rom #(
    .ADDR_W  (ADDR_W),
    .NOTE_W  (NOTE_W),
    .DUR_W   (DUR_W),
    .SONG_LEN(SONG_LEN)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr_i(addr_q),
    .data_o(rom_data)
  );

  assign rom_note   = rom_data[NOTE_LSB +: NOTE_W];
  assign rom_dur    = rom_data[dur_lsb(NOTE_W) +: DUR_W];
  // >= rather than == so a faster tempo picked mid-tick ends the tick at once
  assign tick_last  = (32'(TICK_DIV) >> bus.tempo_sel) - 32'd1;
  assign tick_end   = 32'(tick_q) >= tick_last;
  assign last_entry = 32'(addr_q) >= SONG_LEN - 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      note_q  <= '0;
      nv_q    <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      nv_q    <= nv_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    nv_d    = 1'b0;
    done_d  = 1'b0;
    tick_d  = tick_q;
    dur_d   = dur_q;
    if (bus.restart) begin
      addr_d  = '0;
      note_d  = NOTE_W'(REST_CODE);
      tick_d  = '0;
      dur_d   = '0;
      state_d = bus.play ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          note_d = NOTE_W'(REST_CODE);
          if (bus.play) state_d = S_FETCH;
        end
        S_FETCH: if (bus.play) state_d = S_LOAD;
        S_LOAD: if (bus.play) begin
          note_d  = rom_note;
          dur_d   = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
          tick_d  = '0;
          nv_d    = 1'b1;
          state_d = S_HOLD;
        end
        S_HOLD: if (bus.play) begin
          if (tick_end) begin
            tick_d = '0;
            dur_d  = dur_q - DUR_W'(1);
            if (dur_q <= DUR_W'(1)) begin
              if (!last_entry) begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
              end else if (bus.loop_en) begin
                addr_d  = '0;
                state_d = S_FETCH;
              end else begin
                note_d  = NOTE_W'(REST_CODE);
                done_d  = 1'b1;
                state_d = S_DONE;
              end
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: state_d = S_DONE;
      endcase
    end
  end

  always_comb begin
    bus.note       = bus.play ? note_q : '0;
    bus.note_valid = nv_q;
    bus.address    = addr_q;
    bus.song_done  = done_q;
    bus.playing    = bus.play &&
                     (state_q == S_FETCH || state_q == S_LOAD || state_q == S_HOLD);
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer with a fast tick (TICK_DIV=8) and a 16-entry song.
module tb_music_sequencer;
  localparam int unsigned TICK_DIV = 8;
  localparam int unsigned SONG_LEN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  music_sequencer_if #(.NOTE_W(8), .ADDR_W(8)) bus_if ();

  music_sequencer #(
    .NOTE_W  (8),
    .DUR_W   (4),
    .ADDR_W  (8),
    .SONG_LEN(SONG_LEN),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  typedef struct {
    int unsigned addr;
    int unsigned note;
    int          gap;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_nv  = 0;
  int unsigned sd_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_note(input int unsigned i);
    case (i % 8)
      0: return 27;
      1: return 26;
      2: return 27;
      3: return 28;
      4: return 25;
      5: return 26;
      6: return 22;
      default: return 24;
    endcase
  endfunction

  function automatic int unsigned ref_dur(input int unsigned i);
    return ((i % 8) == 7) ? 2 : 1;
  endfunction

  // cycles between note_valid pulses when entry i follows its predecessor at a given tempo
  function automatic int gap_after_prev(input int unsigned i, input int unsigned tempo);
    return int'(ref_dur((i + SONG_LEN - 1) % SONG_LEN) * (TICK_DIV >> tempo) + 2);
  endfunction

  task automatic push(input int unsigned a, input int gap);
    exp_t e;
    e.addr = a;
    e.note = ref_note(a);
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_nv(input int unsigned a, input string tag);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus_if.note_valid && 32'(bus_if.address) == a) && n < 400);
    if (n >= 400) check_eq(tag, 32'(bus_if.address), a);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus_if.song_done) sd_count++;
    if (bus_if.note_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("nv_unexpected_addr", 32'(bus_if.address), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("nv_addr", 32'(bus_if.address), e.addr);
        check_eq("nv_note", 32'(bus_if.note), e.note);
        if (e.gap >= 0) check_eq("nv_gap", cyc - last_nv, 32'(e.gap));
      end
      last_nv = cyc;
    end
  end

  initial begin
    int unsigned n;
    bus_if.play      = 1'b0;
    bus_if.restart   = 1'b0;
    bus_if.loop_en   = 1'b0;
    bus_if.tempo_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_note", 32'(bus_if.note), 0);
    check_eq("rst_nv", 32'(bus_if.note_valid), 0);
    check_eq("rst_addr", 32'(bus_if.address), 0);
    check_eq("rst_playing", 32'(bus_if.playing), 0);
    check_eq("rst_done", 32'(bus_if.song_done), 0);

    // full song, no loop
    push(0, -1);
    for (int unsigned i = 1; i < SONG_LEN; i++) push(i, gap_after_prev(i, 0));
    bus_if.play = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("first_note", 32'(bus_if.note), 27);
    check_eq("first_nv", 32'(bus_if.note_valid), 1);
    check_eq("first_playing", 32'(bus_if.playing), 1);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.song_done && n < 400);
    check_eq("done_seen", 32'(bus_if.song_done), 1);
    check_eq("done_note", 32'(bus_if.note), 0);
    check_eq("done_addr", 32'(bus_if.address), SONG_LEN - 1);
    check_eq("done_playing", 32'(bus_if.playing), 0);
    repeat (50) @(negedge clk);
    check_eq("done_hold_addr", 32'(bus_if.address), SONG_LEN - 1);
    check_eq("done_hold_playing", 32'(bus_if.playing), 0);
    check_eq("done_hold_note", 32'(bus_if.note), 0);
    check_eq("done_pulses", sd_count, 1);
    check_eq("song_drained", 32'(exp_q.size()), 0);

    // looping: two passes up to entry 12 of the second pass
    push(0, -1);
    for (int unsigned i = 1; i < SONG_LEN; i++) push(i, gap_after_prev(i, 0));
    for (int unsigned i = 0; i <= 12; i++) push(i, gap_after_prev(i, 0));
    // then restart, pause inside entry 0, tempo change inside entry 1
    push(0, -1);
    push(1, 30);
    push(2, 8);
    for (int unsigned i = 3; i <= 7; i++) push(i, gap_after_prev(i, 3));
    push(8, gap_after_prev(8, 0));

    bus_if.loop_en = 1'b1;
    bus_if.restart = 1'b1;
    @(negedge clk);
    bus_if.restart = 1'b0;
    wait_nv(12, "wait_pass1_12");
    wait_nv(12, "wait_pass2_12");
    check_eq("loop_no_done", sd_count, 1);

    bus_if.restart = 1'b1;
    @(negedge clk);
    bus_if.restart = 1'b0;
    check_eq("rs_addr", 32'(bus_if.address), 0);
    check_eq("rs_note", 32'(bus_if.note), 0);
    check_eq("rs_playing", 32'(bus_if.playing), 1);
    @(negedge clk);
    check_eq("rs_nv_early", 32'(bus_if.note_valid), 0);
    @(negedge clk);
    check_eq("rs_nv", 32'(bus_if.note_valid), 1);
    check_eq("rs_note27", 32'(bus_if.note), 27);

    // pause three cycles into the hold
    repeat (3) @(negedge clk);
    bus_if.play = 1'b0;
    #1;
    check_eq("pause_note", 32'(bus_if.note), 0);
    check_eq("pause_playing", 32'(bus_if.playing), 0);
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.note !== 8'd0 || bus_if.playing !== 1'b0 || bus_if.address !== 8'd0)
        check_eq("pause_frozen", {bus_if.note, bus_if.address, 7'd0, bus_if.playing}, 32'd0);
    end
    bus_if.play = 1'b1;
    #1;
    check_eq("resume_note", 32'(bus_if.note), 27);

    // tempo x8 picked when the tick counter sits at 5
    wait_nv(1, "wait_tempo_entry");
    repeat (5) @(negedge clk);
    bus_if.tempo_sel = 2'd3;
    wait_nv(7, "wait_fast_7");
    bus_if.tempo_sel = 2'd0;
    wait_nv(8, "wait_slow_8");

    // asynchronous reset mid-hold
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_note", 32'(bus_if.note), 0);
    check_eq("arst_nv", 32'(bus_if.note_valid), 0);
    check_eq("arst_addr", 32'(bus_if.address), 0);
    check_eq("arst_playing", 32'(bus_if.playing), 0);
    check_eq("arst_done", 32'(bus_if.song_done), 0);
    bus_if.play    = 1'b0;
    bus_if.loop_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("final_drained", 32'(exp_q.size()), 0);
    check_eq("final_done_pulses", sd_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
